// File: rtl/demux_bit_sequencer.sv
`default_nettype none
// demux_bit_sequencer: accepts one byte per valid/ready handshake and presents it
// serially to a 1x8 demux, with sel always equal to the index of the bit on ser_out.
module demux_bit_sequencer #(
  parameter int MSB_FIRST = 0,
  parameter int IDLE_GAP  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic       hold,
  output logic       ser_out,
  output logic       sel2,
  output logic       sel1,
  output logic       sel0,
  output logic       ser_valid,
  output logic       frame_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP > 0 ? IDLE_GAP - 1 : 0);

  state_t     state, state_n;
  logic [3:0] p, p_n;
  logic [7:0] byte_q, byte_n;
  logic [3:0] gap_cnt, gap_cnt_n;
  logic [2:0] sel, sel_n;
  logic       ser_out_n;
  logic       ser_valid_n;
  logic       frame_done_n;
  logic [2:0] first_idx;
  logic [2:0] step_idx;

  // Descending order is the bitwise complement of the step for a 3-bit index.
  function automatic logic [2:0] bit_index(input logic [2:0] step);
    return (MSB_FIRST != 0) ? ~step : step;
  endfunction

  assign first_idx  = bit_index(3'd0);
  assign step_idx   = bit_index(p[2:0]);
  assign data_ready = (state == IDLE);
  assign {sel2, sel1, sel0} = sel;

  always_comb begin
    state_n      = state;
    p_n          = p;
    byte_n       = byte_q;
    gap_cnt_n    = gap_cnt;
    sel_n        = sel;
    ser_out_n    = 1'b0;
    ser_valid_n  = 1'b0;
    frame_done_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (data_valid) begin
          byte_n      = data_in;
          sel_n       = first_idx;
          ser_out_n   = data_in[first_idx];
          ser_valid_n = 1'b1;
          p_n         = 4'd1;
          state_n     = SHIFT;
        end
      end
      SHIFT: begin
        if (!hold) begin
          // p only reaches 8 after the last bit, so p[3] marks end of frame.
          if (p[3]) begin
            frame_done_n = 1'b1;
            p_n          = 4'd0;
            gap_cnt_n    = 4'd0;
            state_n      = (IDLE_GAP > 0) ? GAP : IDLE;
          end else begin
            sel_n       = step_idx;
            ser_out_n   = byte_q[step_idx];
            ser_valid_n = 1'b1;
            p_n         = p + 4'd1;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = IDLE;
        end else begin
          gap_cnt_n = gap_cnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      p          <= 4'd0;
      byte_q     <= 8'd0;
      gap_cnt    <= 4'd0;
      sel        <= 3'd0;
      ser_out    <= 1'b0;
      ser_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      p          <= p_n;
      byte_q     <= byte_n;
      gap_cnt    <= gap_cnt_n;
      sel        <= sel_n;
      ser_out    <= ser_out_n;
      ser_valid  <= ser_valid_n;
      frame_done <= frame_done_n;
      busy       <= (state_n != IDLE);
    end
  end

endmodule
`default_nettype wire
